// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; value is registered, updates one cycle after inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] out
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign out = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubble, mispredict flush/redirect, memory freeze.
// Control outputs are combinational (zero latency); counters and mem_timeout are registered.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MAX_WAIT         = 64,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_addr_id,
    input  logic [4:0]       rs2_addr_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             memtoreg_ex,
    input  logic             wb_reg_file_ex,
    input  logic             mispredict_ex,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [1:0]      BUB_INIT = 2'(REDIRECT_BUBBLES);

    hz_state_t         state_q, state_d;
    hz_state_t         resume_q, resume_d;
    hz_state_t         eff_state;
    logic [1:0]        bubble_q, bubble_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              load_use;
    logic              flush_evt;

    assign load_use = memtoreg_ex && wb_reg_file_ex && (rd_ex != REG_ZERO) &&
                      ((uses_rs1_id && (rs1_addr_id == rd_ex)) ||
                       (uses_rs2_id && (rs2_addr_id == rd_ex)));

    // On release from MEM_WAIT, behave as the state that was frozen.
    assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        state_d     = state_q;
        resume_d    = resume_q;
        bubble_d    = bubble_q;
        wait_d      = '0;
        timeout_d   = timeout_q;
        flush_evt   = 1'b0;

        if (dmem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            state_d   = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                resume_d = state_q;
            end
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
            if (wait_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end else if (mispredict_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
                bubble_d = BUB_INIT;
                state_d  = REDIRECT;
            end else begin
                bubble_d = 2'd0;
                state_d  = RUN;
            end
        end else if (eff_state == REDIRECT) begin
            // ID holds a bubble here, so load_use is irrelevant.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (bubble_q <= 2'd1) begin
                bubble_d = 2'd0;
                state_d  = RUN;
            end else begin
                bubble_d = bubble_q - 2'd1;
                state_d  = REDIRECT;
            end
        end else begin
            state_d = RUN;
            if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            resume_q  <= RUN;
            bubble_q  <= 2'd0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            bubble_q  <= bubble_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (~pc_en),
        .clr (~rst_n),
        .out (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .inc (flush_evt),
        .clr (~rst_n),
        .out (flush_cnt)
    );

endmodule
